// File: rtl/disp_arbiter_pkg.sv
// Shared codes for the display arbiter: owner codes, timer states, FSM states and a nibble helper.
package disp_arbiter_pkg;

  // Display owner codes as seen on the owner output
  typedef enum logic [1:0] {
    OWN_CLK = 2'd0,
    OWN_TMR = 2'd1,
    OWN_SW  = 2'd2
  } owner_e;

  // Timer states, matching the TimerController encoding
  localparam logic [1:0] TS_IDLE    = 2'd0;
  localparam logic [1:0] TS_SETTING = 2'd1;
  localparam logic [1:0] TS_RUNNING = 2'd2;
  localparam logic [1:0] TS_RINGING = 2'd3;

  // Popup FSM states
  typedef enum logic [1:0] {
    StFollow   = 2'd0,
    StPopTimer = 2'd1,
    StPopAlarm = 2'd2
  } state_e;

  // User mode to owner; the unused code 3 falls back to the clock
  function automatic owner_e mode_to_owner(input logic [1:0] mode);
    owner_e o;
    case (mode)
      2'd1:    o = OWN_TMR;
      2'd2:    o = OWN_SW;
      default: o = OWN_CLK;
    endcase
    return o;
  endfunction

  // Scan index 0 is h_tens (top nibble), index 5 is s_ones (bottom nibble)
  function automatic logic [3:0] digit_nibble(input logic [23:0] bus, input logic [2:0] idx);
    logic [3:0] n;
    case (idx)
      3'd0:    n = bus[23:20];
      3'd1:    n = bus[19:16];
      3'd2:    n = bus[15:12];
      3'd3:    n = bus[11:8];
      3'd4:    n = bus[7:4];
      3'd5:    n = bus[3:0];
      default: n = 4'd0;
    endcase
    return n;
  endfunction

endpackage

// File: rtl/disp_arbiter_scan_seq.sv
// Digit scan sequencer: divider, digit index and registered one-hot digit enable.
module disp_arbiter_scan_seq #(
  parameter int unsigned SCAN_DIV = 2
) (
  input  logic       clk_1k,
  input  logic       rst,
  output logic [2:0] idx_next,
  output logic [5:0] digit_sel
);

  localparam logic [7:0] DivLast = 8'(SCAN_DIV - 1);

  logic [7:0] div_q, div_d;
  logic [2:0] idx_q;

  // Next divider count and digit index; idx_next is exported so the caller can
  // register seg_bcd in step with digit_sel
  always_comb begin
    div_d    = div_q + 8'd1;
    idx_next = idx_q;
    if (div_q == DivLast) begin
      div_d    = 8'd0;
      idx_next = (idx_q == 3'd5) ? 3'd0 : idx_q + 3'd1;
    end
  end

  // Divider, index and one-hot enable registers
  always_ff @(posedge clk_1k) begin
    if (rst) begin
      div_q     <= 8'd0;
      idx_q     <= 3'd0;
      digit_sel <= 6'b100000;
    end else begin
      div_q     <= div_d;
      idx_q     <= idx_next;
      digit_sel <= 6'b100000 >> idx_next;
    end
  end

endmodule

// File: rtl/disp_arbiter.sv
// Display/piezo owner arbiter with ring popups and 6-digit scan.
module disp_arbiter
  import disp_arbiter_pkg::*;
#(
  parameter int unsigned POPUP_SEC = 10,
  parameter int unsigned SCAN_DIV  = 2
) (
  input  logic        clk_1k,
  input  logic        rst,
  input  logic        tick_1hz,
  input  logic [1:0]  mode_sel,
  input  logic [1:0]  timer_state,
  input  logic        alarm_ring,
  input  logic        btn_dismiss,
  input  logic [23:0] clk_digits,
  input  logic [23:0] tm_digits,
  input  logic [23:0] sw_digits,
  input  logic        timer_piezo,
  input  logic        alarm_piezo,
  output logic [1:0]  owner,
  output logic        popup,
  output logic [5:0]  digit_sel,
  output logic [3:0]  seg_bcd,
  output logic        piezo_out
);

  localparam logic [5:0] SecLast = 6'(POPUP_SEC - 1);

  logic        tmr_ring_q, tmr_ring_qq, alm_ring_q, alm_ring_qq;
  logic        tmr_start, alm_start, tick_last;
  state_e      state_q, state_d;
  logic [5:0]  sec_cnt_q, sec_cnt_d;
  owner_e      owner_q, owner_d;
  logic        popup_q;
  logic [3:0]  seg_q;
  logic        piezo_q;
  logic [2:0]  idx_next;
  logic [23:0] own_bus;

  disp_arbiter_scan_seq #(
    .SCAN_DIV(SCAN_DIV)
  ) u_scan (
    .clk_1k   (clk_1k),
    .rst      (rst),
    .idx_next (idx_next),
    .digit_sel(digit_sel)
  );

  // Two-stage history of each ring condition for start-edge detection
  always_ff @(posedge clk_1k) begin
    if (rst) begin
      tmr_ring_q  <= 1'b0;
      tmr_ring_qq <= 1'b0;
      alm_ring_q  <= 1'b0;
      alm_ring_qq <= 1'b0;
    end else begin
      tmr_ring_q  <= (timer_state == TS_RINGING);
      tmr_ring_qq <= tmr_ring_q;
      alm_ring_q  <= alarm_ring;
      alm_ring_qq <= alm_ring_q;
    end
  end

  assign tmr_start = tmr_ring_q & ~tmr_ring_qq;
  assign alm_start = alm_ring_q & ~alm_ring_qq;
  assign tick_last = tick_1hz && (sec_cnt_q == SecLast);

  // Popup FSM next state, second counter and owner/bus selection
  always_comb begin
    state_d   = state_q;
    sec_cnt_d = sec_cnt_q;
    unique case (state_q)
      StFollow: begin
        if (alm_start) begin
          state_d   = StPopAlarm;
          sec_cnt_d = 6'd0;
        end else if (tmr_start) begin
          state_d   = StPopTimer;
          sec_cnt_d = 6'd0;
        end
      end
      StPopTimer: begin
        // Alarm preempts a timer popup and restarts the popup time
        if (alm_start) begin
          state_d   = StPopAlarm;
          sec_cnt_d = 6'd0;
        end else if (btn_dismiss || !tmr_ring_q || tick_last) begin
          state_d   = StFollow;
          sec_cnt_d = 6'd0;
        end else if (tick_1hz) begin
          sec_cnt_d = sec_cnt_q + 6'd1;
        end
      end
      StPopAlarm: begin
        if (btn_dismiss || !alm_ring_q || tick_last) begin
          state_d   = StFollow;
          sec_cnt_d = 6'd0;
        end else if (tick_1hz) begin
          sec_cnt_d = sec_cnt_q + 6'd1;
        end
      end
      default: begin
        state_d   = StFollow;
        sec_cnt_d = 6'd0;
      end
    endcase

    case (state_d)
      StPopTimer: owner_d = OWN_TMR;
      StPopAlarm: owner_d = OWN_CLK;
      default:    owner_d = mode_to_owner(mode_sel);
    endcase

    case (owner_d)
      OWN_TMR: own_bus = tm_digits;
      OWN_SW:  own_bus = sw_digits;
      default: own_bus = clk_digits;
    endcase
  end

  // FSM state plus registered outputs
  always_ff @(posedge clk_1k) begin
    if (rst) begin
      state_q   <= StFollow;
      sec_cnt_q <= 6'd0;
      owner_q   <= OWN_CLK;
      popup_q   <= 1'b0;
      seg_q     <= 4'd0;
      piezo_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      sec_cnt_q <= sec_cnt_d;
      owner_q   <= owner_d;
      popup_q   <= (state_d != StFollow);
      seg_q     <= digit_nibble(own_bus, idx_next);
      // Buzzer follows whichever source rings, alarm first, regardless of owner
      if (alarm_ring)                       piezo_q <= alarm_piezo;
      else if (timer_state == TS_RINGING)   piezo_q <= timer_piezo;
      else                                  piezo_q <= 1'b0;
    end
  end

  assign owner     = owner_q;
  assign popup     = popup_q;
  assign seg_bcd   = seg_q;
  assign piezo_out = piezo_q;

endmodule

// File: tb/tb_disp_arbiter.sv
// Scoreboard bench for disp_arbiter: driver + reference model push expectations, monitor compares.
module tb_disp_arbiter;

  localparam int POPUP_SEC = 10;
  localparam int SCAN_DIV  = 2;
  localparam int NCYC      = 5000;

  logic        clk_1k = 1'b0;
  logic        rst;
  logic        tick_1hz;
  logic [1:0]  mode_sel;
  logic [1:0]  timer_state;
  logic        alarm_ring;
  logic        btn_dismiss;
  logic [23:0] clk_digits, tm_digits, sw_digits;
  logic        timer_piezo, alarm_piezo;
  logic [1:0]  owner;
  logic        popup;
  logic [5:0]  digit_sel;
  logic [3:0]  seg_bcd;
  logic        piezo_out;

  disp_arbiter #(
    .POPUP_SEC(POPUP_SEC),
    .SCAN_DIV (SCAN_DIV)
  ) dut (
    .clk_1k     (clk_1k),
    .rst        (rst),
    .tick_1hz   (tick_1hz),
    .mode_sel   (mode_sel),
    .timer_state(timer_state),
    .alarm_ring (alarm_ring),
    .btn_dismiss(btn_dismiss),
    .clk_digits (clk_digits),
    .tm_digits  (tm_digits),
    .sw_digits  (sw_digits),
    .timer_piezo(timer_piezo),
    .alarm_piezo(alarm_piezo),
    .owner      (owner),
    .popup      (popup),
    .digit_sel  (digit_sel),
    .seg_bcd    (seg_bcd),
    .piezo_out  (piezo_out)
  );

  always #5 clk_1k = ~clk_1k;

  typedef struct packed {
    logic [1:0] owner;
    logic       popup;
    logic [5:0] dsel;
    logic [3:0] seg;
    logic       piezo;
  } exp_t;

  exp_t exp_q[$];
  int   vectors = 0;
  int   miscompares = 0;

  // Reference model state: popup source (0 none, 1 timer, 2 alarm), seconds shown,
  // cycles since reset, and the last two sampled values of each ring condition.
  int src, secs, cyc;
  bit t1, t2, a1, a2;

  function automatic exp_t model_step();
    exp_t e;
    bit ts, as_;
    int own, idx;
    logic [23:0] bus;
    if (rst) begin
      src = 0; secs = 0; cyc = 0;
      t1 = 0; t2 = 0; a1 = 0; a2 = 0;
      e = '{owner: 2'd0, popup: 1'b0, dsel: 6'b100000, seg: 4'd0, piezo: 1'b0};
      return e;
    end
    ts  = t1 && !t2;
    as_ = a1 && !a2;
    if (src == 0) begin
      if (as_)     begin src = 2; secs = 0; end
      else if (ts) begin src = 1; secs = 0; end
    end else if (src == 1 && as_) begin
      src = 2; secs = 0;
    end else begin
      if (tick_1hz) secs++;
      if (btn_dismiss || secs >= POPUP_SEC || (src == 1 && !t1) || (src == 2 && !a1)) src = 0;
    end
    t2 = t1; t1 = (timer_state == 2'd3);
    a2 = a1; a1 = alarm_ring;
    if (src == 2)      own = 0;
    else if (src == 1) own = 1;
    else               own = (mode_sel == 2'd3) ? 0 : int'(mode_sel);
    cyc++;
    idx = (cyc / SCAN_DIV) % 6;
    bus = (own == 0) ? clk_digits : (own == 1) ? tm_digits : sw_digits;
    e.owner = 2'(own);
    e.popup = (src != 0);
    e.dsel  = 6'(6'b100000 >> idx);
    e.seg   = 4'((bus >> (4 * (5 - idx))) & 24'hF);
    e.piezo = alarm_ring ? alarm_piezo : (timer_state == 2'd3) ? timer_piezo : 1'b0;
    return e;
  endfunction

  // Monitor: just after each active edge, pop and compare the pending expectation
  initial begin
    exp_t e;
    forever begin
      @(posedge clk_1k);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        vectors++;
        if (owner !== e.owner || popup !== e.popup || digit_sel !== e.dsel ||
            seg_bcd !== e.seg || piezo_out !== e.piezo) begin
          miscompares++;
          $display("FAIL outputs @%0t: got owner=%0d popup=%0b dsel=%b seg=%0d piezo=%0b, want owner=%0d popup=%0b dsel=%b seg=%0d piezo=%0b",
                   $time, owner, popup, digit_sel, seg_bcd, piezo_out,
                   e.owner, e.popup, e.dsel, e.seg, e.piezo);
        end
      end
    end
  end

  // Driver: directed opening from the plan, then random traffic
  initial begin
    rst = 1; tick_1hz = 0; mode_sel = 0; timer_state = 0; alarm_ring = 0; btn_dismiss = 0;
    clk_digits = 24'h123456; tm_digits = 24'h000005; sw_digits = 24'h987654;
    timer_piezo = 0; alarm_piezo = 0;
    for (int n = 0; n < NCYC; n++) begin
      @(negedge clk_1k);
      timer_piezo = 1'($urandom);
      alarm_piezo = 1'($urandom);
      btn_dismiss = 0;
      tick_1hz    = 0;
      if (n < 2) begin
        rst = 1;
      end else if (n < 120) begin
        rst = 0;
        mode_sel = (n < 20) ? 2'd1 : 2'd2;
        if (n == 20) timer_state = 2'd2;
        if (n == 24) timer_state = 2'd3;
        tick_1hz = (n > 24) && (n % 3 == 0);
        if (n == 100) alarm_ring = 1;
        if (n == 110) btn_dismiss = 1;
      end else begin
        rst = ($urandom_range(0, 599) == 0);
        tick_1hz = ($urandom_range(0, 3) == 0);
        btn_dismiss = ($urandom_range(0, 149) == 0);
        if ($urandom_range(0, 47) == 0)
          timer_state = ($urandom_range(0, 1) == 0) ? 2'd3 : 2'($urandom_range(0, 2));
        if ($urandom_range(0, 79) == 0) alarm_ring = ~alarm_ring;
        if ($urandom_range(0, 49) == 0) mode_sel = 2'($urandom_range(0, 3));
        if ($urandom_range(0, 29) == 0) clk_digits = 24'($urandom);
        if ($urandom_range(0, 29) == 0) tm_digits  = 24'($urandom);
        if ($urandom_range(0, 29) == 0) sw_digits  = 24'($urandom);
      end
      exp_q.push_back(model_step());
    end
    @(posedge clk_1k);
    #2;
    if (exp_q.size() != 0) begin
      miscompares++;
      $display("FAIL drain: got %0d pending expectations, want 0", exp_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
